// File: rtl/mcu_subsys_pkg.sv
// Shared types and constants for the mcu_subsys memory bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mcu_subsys_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // Master ids as carried on the grant output
    localparam logic MST_CPU = 1'b0;
    localparam logic MST_DMA = 1'b1;

    // Read data returned to a master whose transaction was cut short
    localparam logic [31:0] DEF_TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mcu_subsys_bus_watchdog.sv
// Per-transaction stall watchdog: counts BUSY cycles, flags the last allowed one.
// Latency: expire is combinational from the count; the count advances once per BUSY cycle.
// Backpressure: none; the counter holds at its limit and clears whenever run is low.
module mcu_subsys_bus_watchdog
    import mcu_subsys_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic run,
    input  logic done,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic [CW-1:0] count;

    // Last permitted BUSY cycle; only meaningful while a transaction is running
    assign expire = run && (count == LAST_CNT);

    // Clear outside BUSY; advance only while neither completion nor expiry is happening,
    // so the count stops at LAST_CNT and can never wrap
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            count <= '0;
        end else if (!run) begin
            count <= '0;
        end else if (!done && !expire) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/mcu_subsys_mem_arbiter.sv
// Round-robin two-master arbiter for the mcu_subsys native memory bus, with stall watchdog.
// Latency: one IDLE cycle of arbitration, then the slave response passes straight through.
// Backpressure: the losing master simply holds valid; its request is served after the current one.
module mcu_subsys_mem_arbiter
    import mcu_subsys_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] TIMEOUT_RDATA  = DEF_TIMEOUT_RDATA
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        m0_mem_valid,
    output logic        m0_mem_ready,
    input  logic [31:0] m0_mem_addr,
    input  logic [31:0] m0_mem_wdata,
    input  logic [3:0]  m0_mem_wstrb,
    output logic [31:0] m0_mem_rdata,
    input  logic        m1_mem_valid,
    output logic        m1_mem_ready,
    input  logic [31:0] m1_mem_addr,
    input  logic [31:0] m1_mem_wdata,
    input  logic [3:0]  m1_mem_wstrb,
    output logic [31:0] m1_mem_rdata,
    output logic        s_mem_valid,
    input  logic        s_mem_ready,
    output logic [31:0] s_mem_addr,
    output logic [31:0] s_mem_wdata,
    output logic [3:0]  s_mem_wstrb,
    input  logic [31:0] s_mem_rdata,
    output logic        grant,
    output logic        busy,
    output logic        timeout_err,
    output logic        timeout_master,
    input  logic        err_clr
);

    arb_state_e  state;
    logic        last_grant;
    logic        next_grant;
    logic        expire;
    logic        tmo_fire;
    logic        complete;
    logic [31:0] resp_data;

    assign busy = (state == ARB_BUSY);

    // A timeout only counts when the slave did not answer in that same cycle
    assign tmo_fire = busy && !s_mem_ready && expire;

    // Response goes out on real completion or forced expiry; never while reset is held
    assign complete  = busy && !rst && (s_mem_ready || expire);
    assign resp_data = s_mem_ready ? s_mem_rdata : TIMEOUT_RDATA;

    mcu_subsys_bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .sys_clk(sys_clk),
        .rst    (rst),
        .run    (busy),
        .done   (s_mem_ready),
        .expire (expire)
    );

    // Arbitration decision: a lone requester wins, a tie goes opposite to the last owner
    always_comb begin
        next_grant = MST_CPU;
        if (m0_mem_valid && m1_mem_valid) begin
            next_grant = ~last_grant;
        end else if (m1_mem_valid) begin
            next_grant = MST_DMA;
        end
    end

    // Arbiter FSM: grant in IDLE, hold the grant until completion or expiry
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            grant      <= MST_CPU;
            last_grant <= MST_DMA;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (m0_mem_valid || m1_mem_valid) begin
                        grant <= next_grant;
                        state <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (s_mem_ready || expire) begin
                        last_grant <= grant;
                        state      <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // Sticky timeout flag; a timeout in the same cycle as err_clr keeps the flag set
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            timeout_err    <= 1'b0;
            timeout_master <= MST_CPU;
        end else if (tmo_fire) begin
            timeout_err    <= 1'b1;
            timeout_master <= grant;
        end else if (err_clr) begin
            timeout_err <= 1'b0;
        end
    end

    // Slave-side mux from the owning master; quiet zeros outside BUSY
    always_comb begin
        s_mem_valid = busy;
        s_mem_addr  = '0;
        s_mem_wdata = '0;
        s_mem_wstrb = '0;
        if (busy) begin
            if (grant == MST_DMA) begin
                s_mem_addr  = m1_mem_addr;
                s_mem_wdata = m1_mem_wdata;
                s_mem_wstrb = m1_mem_wstrb;
            end else begin
                s_mem_addr  = m0_mem_addr;
                s_mem_wdata = m0_mem_wdata;
                s_mem_wstrb = m0_mem_wstrb;
            end
        end
    end

    // Master-side return path: only the owner sees ready, rdata is zero whenever ready is low
    always_comb begin
        m0_mem_ready = complete && (grant == MST_CPU);
        m1_mem_ready = complete && (grant == MST_DMA);
        m0_mem_rdata = m0_mem_ready ? resp_data : '0;
        m1_mem_rdata = m1_mem_ready ? resp_data : '0;
    end

endmodule
